// File: rtl/eje7_sweep_ctrl.sv
// eje7_sweep_ctrl: walks all 16 {A,B,C,D} vectors (and the 8 {x,y,z} vectors)
// through the eje7 block. For each vector it waits SETTLE cycles, then compares
// every original output with its simplified counterpart. At the end it reports
// the mismatch count, the first failing vector and an overall pass flag.
module eje7_sweep_ctrl #(
    parameter logic [3:0] SETTLE = 4'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       Y,
    input  logic       Y_2,
    input  logic       Z,
    input  logic       Z_2,
    input  logic       F2,
    input  logic       F2_2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_vec,
    output logic [2:0] fail_mask
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_FINISH
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  idx;
    logic [3:0]  next_idx;
    logic [3:0]  settle_cnt;
    logic [2:0]  xyz_q;
    logic        first_seen;
    logic [2:0]  mismatch;

    // The vector index doubles as the {A,B,C,D} register, so the eje7 inputs
    // always come straight from flops.
    assign {A, B, C, D} = idx;
    assign {x, y, z}    = xyz_q;
    assign next_idx     = idx + 4'd1;
    assign mismatch     = {Y ^ Y_2, Z ^ Z_2, F2 ^ F2_2};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one DRIVE cycle, SETTLE wait cycles, one CHECK cycle per vector.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                next_state = (SETTLE == 4'd0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd1) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                next_state = (idx == 4'hF) ? ST_FINISH : ST_DRIVE;
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs; results hold until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= 4'd0;
            xyz_q      <= 3'd0;
            settle_cnt <= 4'd0;
            first_seen <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 5'd0;
            fail_vec   <= 4'd0;
            fail_mask  <= 3'd0;
        end else begin
            busy <= (next_state != ST_IDLE);
            done <= (next_state == ST_FINISH);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= 4'd0;
                        xyz_q      <= 3'd0;
                        first_seen <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 5'd0;
                        fail_vec   <= 4'd0;
                        fail_mask  <= 3'd0;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CHECK: begin
                    if (mismatch != 3'd0) begin
                        if (err_count != 5'd31) begin
                            err_count <= err_count + 5'd1;
                        end
                        if (!first_seen) begin
                            fail_vec   <= idx;
                            fail_mask  <= mismatch;
                            first_seen <= 1'b1;
                        end
                    end
                    if (idx != 4'hF) begin
                        idx   <= next_idx;
                        xyz_q <= next_idx[3] ? 3'b111 : next_idx[2:0];
                    end
                end
                ST_FINISH: begin
                    pass <= (err_count == 5'd0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eje7_sweep_ctrl.sv
// tb_eje7_sweep_ctrl: three sweep controllers (SETTLE = 1, 0, 4) each drive a
// behavioural eje7 stand-in with programmable per-vector faults and glitches
// outside the sampling cycle. Expected sweep results are queued at stimulus
// time and popped by a monitor thread when done is seen.
module tb_eje7_sweep_ctrl;

    typedef struct {
        int err;
        int fvec;
        int fmask;
        bit pass;
    } sb_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] rst, start, glitch_en, glitch_now;
    logic [2:0] va, vb, vc, vd, vx, vy, vz;
    logic [2:0] y1, y2, z1, z2, f1, f2;
    logic [2:0] busy, done, pass;
    logic [4:0] err_count [3];
    logic [3:0] fail_vec  [3];
    logic [2:0] fail_mask [3];
    logic [2:0] fault_tab [3][16];

    sb_t sb [3][$];
    sb_t cur [3];
    bit  [2:0] have_cur;
    int  phase [3];
    int  sweeps_done [3];

    // Free-running clock.
    always #5 clk = ~clk;

    // One controller per settle setting, each with its own faulty eje7 stand-in.
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 0 : 4;
        logic [3:0] vidx;
        assign vidx    = {va[gi], vb[gi], vc[gi], vd[gi]};
        assign y1[gi]  = (va[gi] & vb[gi]) | (~vc[gi] & vd[gi]);
        assign y2[gi]  = y1[gi] ^ fault_tab[gi][vidx][2] ^ glitch_now[gi];
        assign z1[gi]  = va[gi] ^ vb[gi] ^ vc[gi] ^ vd[gi];
        assign z2[gi]  = z1[gi] ^ fault_tab[gi][vidx][1] ^ glitch_now[gi];
        assign f1[gi]  = (vx[gi] & vy[gi]) | ~vz[gi];
        assign f2[gi]  = f1[gi] ^ fault_tab[gi][vidx][0] ^ glitch_now[gi];

        eje7_sweep_ctrl #(.SETTLE(4'(S))) u_dut (
            .clk       (clk),
            .reset     (rst[gi]),
            .start     (start[gi]),
            .A         (va[gi]),
            .B         (vb[gi]),
            .C         (vc[gi]),
            .D         (vd[gi]),
            .x         (vx[gi]),
            .y         (vy[gi]),
            .z         (vz[gi]),
            .Y         (y1[gi]),
            .Y_2       (y2[gi]),
            .Z         (z1[gi]),
            .Z_2       (z2[gi]),
            .F2        (f1[gi]),
            .F2_2      (f2[gi]),
            .busy      (busy[gi]),
            .done      (done[gi]),
            .pass      (pass[gi]),
            .err_count (err_count[gi]),
            .fail_vec  (fail_vec[gi]),
            .fail_mask (fail_mask[gi])
        );
    end

    function automatic int settleOf(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 4;
    endfunction

    task automatic checkOutput(input int inst, input string what, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL settle%0d %s: got %0d, expected %0d", inst, what, actual, expected);
        end
    endtask

    // Reference result of a sweep: count faulty vectors, remember the first one.
    function automatic sb_t computeExpected(input int i);
        sb_t e;
        e.err = 0;
        e.fvec = 0;
        e.fmask = 0;
        for (int v = 0; v < 16; v++) begin
            if (fault_tab[i][v] != 3'd0) begin
                if (e.err == 0) begin
                    e.fvec  = v;
                    e.fmask = int'(fault_tab[i][v]);
                end
                if (e.err < 31) e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic clearFaults(input int i);
        for (int v = 0; v < 16; v++) fault_tab[i][v] = 3'd0;
    endtask

    task automatic randomFaults(input int i);
        for (int v = 0; v < 16; v++)
            fault_tab[i][v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        glitch_en[i] = 1'($urandom_range(0, 1));
    endtask

    // Monitor: tracks cycles since a sweep was accepted and checks the vector
    // sequence, done timing and final results against the timing rules.
    task automatic monitorStep();
        int s, p, vi;
        for (int i = 0; i < 3; i++) begin
            s = settleOf(i);
            p = s + 2;
            if (rst[i]) begin
                phase[i] = -1;
                glitch_now[i] = 1'b0;
                continue;
            end
            if (phase[i] >= 0) phase[i]++;
            else if (busy[i]) phase[i] = 0;
            if (phase[i] >= 0 && phase[i] < 16 * p) begin
                vi = phase[i] / p;
                checkOutput(s, "vector ABCD", int'({va[i], vb[i], vc[i], vd[i]}), vi);
                checkOutput(s, "vector xyz", int'({vx[i], vy[i], vz[i]}), (vi < 8) ? vi : 7);
                checkOutput(s, "busy in sweep", int'(busy[i]), 1);
                checkOutput(s, "done in sweep", int'(done[i]), 0);
            end else if (phase[i] == 16 * p) begin
                checkOutput(s, "done pulse", int'(done[i]), 1);
                checkOutput(s, "busy at finish", int'(busy[i]), 1);
                if (sb[i].size() == 0) begin
                    checks++;
                    errors++;
                    have_cur[i] = 1'b0;
                    $display("[TB] FAIL settle%0d unexpected sweep: got done, expected none", s);
                end else begin
                    cur[i] = sb[i].pop_front();
                    have_cur[i] = 1'b1;
                    checkOutput(s, "err_count", int'(err_count[i]), cur[i].err);
                    checkOutput(s, "fail_vec", int'(fail_vec[i]), cur[i].fvec);
                    checkOutput(s, "fail_mask", int'(fail_mask[i]), cur[i].fmask);
                end
            end else if (phase[i] == 16 * p + 1) begin
                checkOutput(s, "done after finish", int'(done[i]), 0);
                checkOutput(s, "busy after finish", int'(busy[i]), 0);
                checkOutput(s, "held ABCD", int'({va[i], vb[i], vc[i], vd[i]}), 15);
                checkOutput(s, "held xyz", int'({vx[i], vy[i], vz[i]}), 7);
                if (have_cur[i]) checkOutput(s, "pass", int'(pass[i]), int'(cur[i].pass));
                sweeps_done[i]++;
                phase[i] = -1;
            end
            glitch_now[i] = glitch_en[i] && phase[i] >= 0 && phase[i] < 16 * p && (phase[i] % p) != s + 1;
        end
    endtask

    // Issue a start request and queue the expected result of n sweeps.
    task automatic applyStimulus(input int i, input int n, input bit hold);
        sb_t e;
        int s, p, base, guard, limit;
        s = settleOf(i);
        p = s + 2;
        e = computeExpected(i);
        for (int k = 0; k < n; k++) sb[i].push_back(e);
        base = sweeps_done[i];
        start[i] = 1'b1;
        @(negedge clk); #1;
        checkOutput(s, "start accepted", int'(busy[i]), 1);
        if (!hold) start[i] = 1'b0;
        limit = n * (16 * p + 4) + 20;
        guard = 0;
        while (sweeps_done[i] < base + n && guard < limit) begin
            @(negedge clk); #1;
            guard++;
            if (hold) begin
                if (sweeps_done[i] == base + n - 1 && phase[i] >= 0) start[i] = 1'b0;
                else if (sweeps_done[i] == base && phase[i] == 4 * p + s) start[i] = 1'b0;
                else if (sweeps_done[i] == base && phase[i] == 4 * p + s + 1) start[i] = 1'b1;
            end
        end
        start[i] = 1'b0;
        if (sweeps_done[i] < base + n) begin
            checks++;
            errors++;
            $display("[TB] FAIL settle%0d sweep timeout: got %0d sweeps, expected %0d", s, sweeps_done[i] - base, n);
            sb[i].delete();
        end
    endtask

    // Abort a faulty sweep at vector 9 mid-settle and confirm asynchronous clearing.
    task automatic resetMidSweep(input int i);
        int s, p, guard;
        s = settleOf(i);
        p = s + 2;
        start[i] = 1'b1;
        @(negedge clk); #1;
        start[i] = 1'b0;
        guard = 0;
        while (phase[i] != 9 * p + 1 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        if (phase[i] != 9 * p + 1) begin
            checks++;
            errors++;
            $display("[TB] FAIL settle%0d reach vector 9: got phase %0d, expected %0d", s, phase[i], 9 * p + 1);
        end
        rst[i] = 1'b1;
        #1;
        checkOutput(s, "async reset outputs",
                    int'({va[i], vb[i], vc[i], vd[i], vx[i], vy[i], vz[i], busy[i], done[i], pass[i],
                          err_count[i], fail_vec[i], fail_mask[i]}), 0);
        @(negedge clk); #1;
        rst[i] = 1'b0;
    endtask

    // Main sequence with the monitor running as a decoupled thread.
    initial begin
        rst        = '1;
        start      = '0;
        glitch_en  = '0;
        glitch_now = '0;
        have_cur   = '0;
        for (int i = 0; i < 3; i++) begin
            phase[i] = -1;
            sweeps_done[i] = 0;
            clearFaults(i);
        end
        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        @(negedge clk); #1;
        for (int i = 0; i < 3; i++)
            checkOutput(settleOf(i), "reset outputs",
                        int'({va[i], vb[i], vc[i], vd[i], vx[i], vy[i], vz[i], busy[i], done[i], pass[i],
                              err_count[i], fail_vec[i], fail_mask[i]}), 0);
        rst = '0;
        @(negedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            glitch_en[i] = 1'b1;
            clearFaults(i);
            applyStimulus(i, 1, 1'b0);
        end

        clearFaults(0);
        fault_tab[0][5] = 3'b100;
        applyStimulus(0, 1, 1'b0);

        clearFaults(0);
        fault_tab[0][3]  = 3'b001;
        fault_tab[0][12] = 3'b011;
        applyStimulus(0, 1, 1'b0);

        clearFaults(0);
        fault_tab[0][2] = 3'b010;
        resetMidSweep(0);
        clearFaults(0);
        applyStimulus(0, 1, 1'b0);

        applyStimulus(0, 2, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        checkOutput(1, "no extra sweep", int'(busy[0]), 0);

        for (int r = 0; r < 6; r++) begin
            randomFaults(0);
            applyStimulus(0, 1, 1'b0);
        end
        for (int i = 1; i < 3; i++) begin
            for (int r = 0; r < 2; r++) begin
                randomFaults(i);
                applyStimulus(i, 1, 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++)
            checkOutput(settleOf(i), "pending expectations", sb[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Last-resort guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/eje7_sweep_ctrl.md
# eje7_sweep_ctrl

Sequencer and self-checker for the `eje7` boolean-function block. On a start request it drives all 16 input combinations of A,B,C,D (and the 8 combinations of x,y,z) into `eje7` and waits a programmable settle time. It then compares each original function output against its simplified counterpart (Y/Y_2, Z/Z_2, F2/F2_2) and reports a pass/fail summary. It sits beside `eje7` on the board-level top and replaces manual truth-table inspection of waveforms.

## Interface
- SETTLE, 1: clock cycles between applying a vector and sampling outputs (0..15).
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  sweep request, sampled in IDLE only.
- A, B, C, D  output  1 each  eje7 inputs; {A,B,C,D} = vector index.
- x, y, z  output  1 each  eje7 inputs; {x,y,z} = index[2:0] while index < 8, held at 3'b111 for index ≥ 8.
- Y, Y_2, Z, Z_2, F2, F2_2  input  1 each  eje7 outputs under test.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  1 when the last completed sweep had zero mismatches.
- err_count  output  5  number of failing vectors in the current or last sweep.
- fail_vec  output  4  index of the first failing vector.
- fail_mask  output  3  mismatch bits {Y≠Y_2, Z≠Z_2, F2≠F2_2} at the first failing vector.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, FINISH.
- IDLE: start=1 → DRIVE. On the same edge: idx←0, err_count←0, fail_vec←0, fail_mask←0, pass←0, first-fail flag cleared. Vector registers ← 0. Any other input leaves IDLE unchanged.
- DRIVE (1 cycle): the vector for idx is applied. Settle counter ← SETTLE. Next state is SETTLE, or CHECK if SETTLE=0.
- SETTLE: counter decrements every cycle. At 1 → CHECK. Stays SETTLE cycles total.
- CHECK (1 cycle): m = {Y^Y_2, Z^Z_2, F2^F2_2} is sampled.
  - If m≠0: err_count increments, saturating at 31.
  - If m≠0 and no failure has been recorded yet: fail_vec←idx, fail_mask←m, and the first-fail flag is set.
  - If idx=15 → FINISH. Otherwise idx←idx+1, the new vector is loaded, and the next state is DRIVE.
- FINISH (1 cycle): done=1, pass←(err_count==0) including the CHECK-cycle update, → IDLE.
- After FINISH, pass, err_count, fail_vec and fail_mask hold until the next accepted start.
- Vector registers hold the last vector (4'hF / 3'b111) after FINISH.
- start while busy is ignored, with no queuing.
- x,y,z follow index[2:0] for idx 0..7. From idx=8 onward they stay at 3'b111.

## Timing
- Reset values: state=IDLE; A..D=0; x,y,z=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; fail_mask=0.
- Reset asserted at any point, including mid-sweep, forces all reset values immediately, independent of clk. The first start after release begins a fresh sweep from idx 0.
- All outputs are registered; no combinational path from the eje7 inputs to the outputs.
- Per vector: 2+SETTLE cycles (DRIVE + SETTLE + CHECK).
- start sampled at edge k → busy high from edge k → done high in the cycle after edge k+16·(2+SETTLE) → busy low after the following edge.
- With SETTLE=1: done is high in cycle 49 after start is accepted.
- Inputs from eje7 are sampled only in CHECK. Values seen during DRIVE and SETTLE are never used.
- err_count cannot exceed 16 in practice. Saturation is still required.

## Test plan
- Correct eje7 model, SETTLE=1, start pulse → 16 vectors in order 0..15, x,y,z = 0..7 then held at 7, done at cycle 49, pass=1, err_count=0, fail_mask=0.
- Model with Y_2 inverted at vector 5 only → err_count=1, fail_vec=5, fail_mask=3'b100, pass=0.
- Faults at vector 3 (F2_2 wrong) and vector 12 (Z_2 and F2_2 wrong) → err_count=2, fail_vec=3, fail_mask=3'b001.
- Reset asserted while idx=9, mid-SETTLE → all outputs zero immediately. A new start yields a full clean sweep with pass=1.
- start held high for the whole sweep and re-pulsed during CHECK → exactly one sweep, one done pulse. With start still high, a second sweep begins from IDLE.
- SETTLE=0 and SETTLE=4 builds → done at cycle 33 and cycle 97 respectively. Outputs are sampled only in CHECK: a glitch injected during SETTLE does not count as an error.
